// File: rtl/riscv_pkg.sv
// Shared types for the integer register-file write side.
// Widths, register index/word types and writeback source ids.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] RegAddr;
  typedef logic [XLEN-1:0]       Word;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LOAD,
    WB_MULDIV
  } WbSource;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Result, issue, hazard-lookup and write-port bundle.
// slave is the arbiter; master is the pipeline around it.
interface reg_writeback_arbiter_if;
  import riscv_pkg::*;

  logic   i_alu_valid;
  RegAddr i_alu_rd;
  Word    i_alu_data;

  logic   i_ld_valid;
  logic   o_ld_ready;
  RegAddr i_ld_rd;
  Word    i_ld_data;

  logic   i_md_valid;
  logic   o_md_ready;
  RegAddr i_md_rd;
  Word    i_md_data;

  logic   i_issue_valid;
  RegAddr i_issue_rd;
  logic   o_issue_stall;

  RegAddr i_rs1;
  RegAddr i_rs2;
  logic   o_rs1_busy;
  logic   o_rs2_busy;

  RegAddr o_w_reg;
  logic   o_w_reg_enable;
  Word    o_w_data;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_ld_ready,
    input  i_md_valid, i_md_rd, i_md_data,
    output o_md_ready,
    input  i_issue_valid, i_issue_rd,
    output o_issue_stall,
    input  i_rs1, i_rs2,
    output o_rs1_busy, o_rs2_busy,
    output o_w_reg, o_w_reg_enable, o_w_data
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_ld_ready,
    output i_md_valid, i_md_rd, i_md_data,
    input  o_md_ready,
    output i_issue_valid, i_issue_rd,
    input  o_issue_stall,
    output i_rs1, i_rs2,
    input  o_rs1_busy, o_rs2_busy,
    input  o_w_reg, o_w_reg_enable, o_w_data
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// x0 is never marked; a same-edge set beats a clear.
module wb_scoreboard
  import riscv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue_valid,
  input  RegAddr           i_issue_rd,
  input  logic             i_clr_valid,
  input  RegAddr           i_clr_rd,
  input  RegAddr           i_rs1,
  input  RegAddr           i_rs2,
  output logic             o_issue_stall,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy,
  output logic [NREGS-1:0] o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;
  logic             w_set;

  assign o_issue_stall = i_issue_valid && r_pending[i_issue_rd];
  assign w_set = i_issue_valid && !o_issue_stall
              && (i_issue_rd != '0);

  assign o_rs1_busy = (i_rs1 != '0) && r_pending[i_rs1];
  assign o_rs2_busy = (i_rs2 != '0) && r_pending[i_rs2];
  assign o_pending  = r_pending;

  // clear retiring destination, then apply new issue on top
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_valid) begin
      w_pending_nxt[i_clr_rd] = 1'b0;
    end
    if (w_set) begin
      w_pending_nxt[i_issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // pending bit register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Register-file write port arbiter: ALU first, then
// load / mul-div round-robin, with registered write port.
module reg_writeback_arbiter
  import riscv_pkg::*;
(
  input logic                    i_clk,
  input logic                    i_rst,
  reg_writeback_arbiter_if.slave bus
);

  WbSource          r_rr_ptr;
  WbSource          w_src;
  RegAddr           w_rd;
  Word              w_data;
  logic             w_ld_ready;
  logic             w_md_ready;
  logic             w_clr;
  logic             w_wr;
  logic [NREGS-1:0] w_pending;

  RegAddr           r_w_reg;
  Word              r_w_data;
  logic             r_w_en;

  // readies depend only on valids, ALU presence and rr_ptr
  always_comb begin
    w_ld_ready = 1'b0;
    w_md_ready = 1'b0;
    if (!i_rst && !bus.i_alu_valid) begin
      if (bus.i_ld_valid && bus.i_md_valid) begin
        w_ld_ready = (r_rr_ptr == WB_LOAD);
        w_md_ready = (r_rr_ptr != WB_LOAD);
      end else begin
        w_ld_ready = bus.i_ld_valid;
        w_md_ready = bus.i_md_valid;
      end
    end
  end

  // pick the accepted result for this edge
  always_comb begin
    w_src  = WB_NONE;
    w_rd   = '0;
    w_data = '0;
    unique case (1'b1)
      bus.i_alu_valid: begin
        w_src  = WB_ALU;
        w_rd   = bus.i_alu_rd;
        w_data = bus.i_alu_data;
      end
      (bus.i_ld_valid && w_ld_ready): begin
        w_src  = WB_LOAD;
        w_rd   = bus.i_ld_rd;
        w_data = bus.i_ld_data;
      end
      (bus.i_md_valid && w_md_ready): begin
        w_src  = WB_MULDIV;
        w_rd   = bus.i_md_rd;
        w_data = bus.i_md_data;
      end
      default: ;
    endcase
  end

  assign w_wr  = (w_src != WB_NONE) && (w_rd != '0);
  assign w_clr = (w_src == WB_LOAD) || (w_src == WB_MULDIV);

  // round-robin pointer flips after every ld/md grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= WB_LOAD;
    end else if (w_src == WB_LOAD) begin
      r_rr_ptr <= WB_MULDIV;
    end else if (w_src == WB_MULDIV) begin
      r_rr_ptr <= WB_LOAD;
    end
  end

  // write port register; index/data hold when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w_en   <= 1'b0;
      r_w_reg  <= '0;
      r_w_data <= '0;
    end else begin
      r_w_en <= w_wr;
      if (w_wr) begin
        r_w_reg  <= w_rd;
        r_w_data <= w_data;
      end
    end
  end

  wb_scoreboard u_sb (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue_valid (bus.i_issue_valid),
    .i_issue_rd    (bus.i_issue_rd),
    .i_clr_valid   (w_clr),
    .i_clr_rd      (w_rd),
    .i_rs1         (bus.i_rs1),
    .i_rs2         (bus.i_rs2),
    .o_issue_stall (bus.o_issue_stall),
    .o_rs1_busy    (bus.o_rs1_busy),
    .o_rs2_busy    (bus.o_rs2_busy),
    .o_pending     (w_pending)
  );

  assign bus.o_ld_ready = w_ld_ready;
  assign bus.o_md_ready = w_md_ready;
  assign bus.o_w_reg    = r_w_reg;
  assign bus.o_w_data   = r_w_data;
  // a reset arriving mid-write drops the in-flight write
  assign bus.o_w_reg_enable = r_w_en && !i_rst;

  a_alu_not_pending: assert property (
    @(posedge i_clk) disable iff (i_rst)
    (bus.i_alu_valid && bus.i_alu_rd != '0)
      |-> !w_pending[bus.i_alu_rd]);

  a_ld_pending: assert property (
    @(posedge i_clk) disable iff (i_rst)
    (bus.i_ld_valid && w_ld_ready && bus.i_ld_rd != '0)
      |-> w_pending[bus.i_ld_rd]);

  a_md_pending: assert property (
    @(posedge i_clk) disable iff (i_rst)
    (bus.i_md_valid && w_md_ready && bus.i_md_rd != '0)
      |-> w_pending[bus.i_md_rd]);

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed cases plus
// random traffic checked against a behavioural model.
module tb_reg_writeback_arbiter;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  reg_writeback_arbiter_if bus ();

  reg_writeback_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit          m_pend [32];
  bit          m_pref_md = 1'b0;
  bit          m_en      = 1'b0;
  int unsigned m_reg     = 0;
  int unsigned m_data    = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  task automatic idle();
    bus.i_alu_valid   = 1'b0;
    bus.i_alu_rd      = '0;
    bus.i_alu_data    = '0;
    bus.i_ld_valid    = 1'b0;
    bus.i_ld_rd       = '0;
    bus.i_ld_data     = '0;
    bus.i_md_valid    = 1'b0;
    bus.i_md_rd       = '0;
    bus.i_md_data     = '0;
    bus.i_issue_valid = 1'b0;
    bus.i_issue_rd    = '0;
    bus.i_rs1         = '0;
    bus.i_rs2         = '0;
  endtask

  // model: g = 0 none, 1 alu, 2 load, 3 muldiv
  always @(negedge clk) begin
    int          g;
    int unsigned rd;
    int unsigned dat;
    bit          st;
    #2;
    g = 0;
    if (!rst) begin
      if (bus.i_alu_valid) g = 1;
      else if (bus.i_ld_valid && bus.i_md_valid)
        g = m_pref_md ? 3 : 2;
      else if (bus.i_ld_valid) g = 2;
      else if (bus.i_md_valid) g = 3;
    end
    rd  = 0;
    dat = 0;
    if (g == 1) begin rd = bus.i_alu_rd; dat = bus.i_alu_data; end
    if (g == 2) begin rd = bus.i_ld_rd;  dat = bus.i_ld_data;  end
    if (g == 3) begin rd = bus.i_md_rd;  dat = bus.i_md_data;  end
    st = bus.i_issue_valid && m_pend[bus.i_issue_rd];

    check("ld_ready", 32'(bus.o_ld_ready), 32'(g == 2));
    check("md_ready", 32'(bus.o_md_ready), 32'(g == 3));
    check("stall", 32'(bus.o_issue_stall), 32'(st));
    check("rs1_busy", 32'(bus.o_rs1_busy),
          32'(bus.i_rs1 != 0 && m_pend[bus.i_rs1]));
    check("rs2_busy", 32'(bus.o_rs2_busy),
          32'(bus.i_rs2 != 0 && m_pend[bus.i_rs2]));
    check("w_en", 32'(bus.o_w_reg_enable), 32'(m_en && !rst));
    check("w_reg", 32'(bus.o_w_reg), m_reg);
    check("w_data", bus.o_w_data, m_data);

    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_pref_md = 1'b0;
      m_en      = 1'b0;
      m_reg     = 0;
      m_data    = 0;
    end else begin
      m_en = (g != 0) && (rd != 0);
      if (m_en) begin
        m_reg  = rd;
        m_data = dat;
      end
      if (g >= 2) begin
        m_pref_md = (g == 2);
        if (rd != 0) m_pend[rd] = 1'b0;
      end
      if (bus.i_issue_valid && !st && bus.i_issue_rd != 0)
        m_pend[bus.i_issue_rd] = 1'b1;
    end
  end

  int ldq  [4] = '{10, 12, 12, 14};
  int mdq  [4] = '{11, 11, 13, 13};
  bit expl [4] = '{1, 0, 1, 0};

  initial begin
    int q[$];
    int k;
    int r;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU write, one-cycle enable
    bus.i_alu_valid = 1'b1;
    bus.i_alu_rd    = 5'd5;
    bus.i_alu_data  = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    #3;
    check("t1_reg", 32'(bus.o_w_reg), 32'd5);
    check("t1_en", 32'(bus.o_w_reg_enable), 32'd1);
    check("t1_data", bus.o_w_data, 32'hDEADBEEF);
    @(negedge clk);
    #3;
    check("t1_en_drop", 32'(bus.o_w_reg_enable), 32'd0);

    // load blocked by ALU for two cycles
    @(negedge clk);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = 5'd7;
    @(negedge clk);
    idle();
    bus.i_ld_valid  = 1'b1;
    bus.i_ld_rd     = 5'd7;
    bus.i_ld_data   = 32'h777;
    bus.i_alu_valid = 1'b1;
    bus.i_alu_rd    = 5'd2;
    bus.i_alu_data  = 32'd1;
    bus.i_rs1       = 5'd7;
    #3;
    check("t2_ready0", 32'(bus.o_ld_ready), 32'd0);
    check("t2_busy", 32'(bus.o_rs1_busy), 32'd1);
    @(negedge clk);
    #3;
    check("t2_ready1", 32'(bus.o_ld_ready), 32'd0);
    @(negedge clk);
    bus.i_alu_valid = 1'b0;
    #3;
    check("t2_ready2", 32'(bus.o_ld_ready), 32'd1);
    @(negedge clk);
    idle();
    bus.i_rs1 = 5'd7;
    #3;
    check("t2_busy_drop", 32'(bus.o_rs1_busy), 32'd0);
    check("t2_reg", 32'(bus.o_w_reg), 32'd7);
    check("t2_data", bus.o_w_data, 32'h777);

    // round-robin between load and mul/div
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 10; i <= 14; i++) begin
      bus.i_issue_valid = 1'b1;
      bus.i_issue_rd    = RegAddr'(i);
      @(negedge clk);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_rd    = RegAddr'(ldq[i]);
      bus.i_ld_data  = 32'(ldq[i] + 256);
      bus.i_md_valid = 1'b1;
      bus.i_md_rd    = RegAddr'(mdq[i]);
      bus.i_md_data  = 32'(mdq[i] + 512);
      #3;
      check("t3_ld_ready", 32'(bus.o_ld_ready), 32'(expl[i]));
      check("t3_md_ready", 32'(bus.o_md_ready), 32'(!expl[i]));
      if (i > 0) begin
        check("t3_reg", 32'(bus.o_w_reg),
              32'(expl[i-1] ? ldq[i-1] : mdq[i-1]));
        check("t3_en", 32'(bus.o_w_reg_enable), 32'd1);
      end
      @(negedge clk);
      idle();
    end
    #3;
    check("t3_reg_last", 32'(bus.o_w_reg), 32'd13);
    check("t3_data_last", bus.o_w_data, 32'd525);

    // WAW stall on pending destination
    @(negedge clk);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = 5'd9;
    @(negedge clk);
    bus.i_rs1 = 5'd9;
    #3;
    check("t4_stall", 32'(bus.o_issue_stall), 32'd1);
    check("t4_busy", 32'(bus.o_rs1_busy), 32'd1);
    @(negedge clk);
    bus.i_ld_valid = 1'b1;
    bus.i_ld_rd    = 5'd9;
    bus.i_ld_data  = 32'h99;
    #3;
    check("t4_busy_held", 32'(bus.o_rs1_busy), 32'd1);
    check("t4_ld_ready", 32'(bus.o_ld_ready), 32'd1);
    @(negedge clk);
    idle();
    bus.i_rs1 = 5'd9;
    #3;
    check("t4_reg", 32'(bus.o_w_reg), 32'd9);

    // x0 results accepted but never written
    @(negedge clk);
    bus.i_alu_valid = 1'b1;
    bus.i_alu_rd    = 5'd0;
    bus.i_alu_data  = 32'h1234;
    @(negedge clk);
    idle();
    bus.i_ld_valid = 1'b1;
    bus.i_ld_rd    = 5'd0;
    bus.i_ld_data  = 32'h1234;
    bus.i_rs1      = 5'd14;
    #3;
    check("t5_ld_ready", 32'(bus.o_ld_ready), 32'd1);
    check("t5_en_alu", 32'(bus.o_w_reg_enable), 32'd0);
    check("t5_data_hold", bus.o_w_data, 32'h99);
    @(negedge clk);
    idle();
    bus.i_rs1 = 5'd14;
    #3;
    check("t5_en_ld", 32'(bus.o_w_reg_enable), 32'd0);
    check("t5_busy14", 32'(bus.o_rs1_busy), 32'd1);

    // reset during an in-flight write
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = 5'd3;
    @(negedge clk);
    bus.i_issue_rd = 5'd4;
    @(negedge clk);
    idle();
    bus.i_ld_valid = 1'b1;
    bus.i_ld_rd    = 5'd3;
    bus.i_ld_data  = 32'h33;
    #3;
    check("t6_ld_ready", 32'(bus.o_ld_ready), 32'd1);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #3;
    check("t6_en_drop", 32'(bus.o_w_reg_enable), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_rs1 = 5'd4;
    bus.i_rs2 = 5'd3;
    #3;
    check("t6_busy4", 32'(bus.o_rs1_busy), 32'd0);
    check("t6_busy3", 32'(bus.o_rs2_busy), 32'd0);
    check("t6_en", 32'(bus.o_w_reg_enable), 32'd0);

    // random traffic obeying the issue protocol
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      idle();
      rst = ($urandom_range(0, 199) == 0);
      q = {};
      for (int i = 1; i < 32; i++)
        if (m_pend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        bus.i_ld_valid = 1'b1;
        bus.i_ld_rd    = RegAddr'(q[k]);
        bus.i_ld_data  = $urandom;
        q.delete(k);
      end
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        bus.i_md_valid = 1'b1;
        bus.i_md_rd    = RegAddr'(q[k]);
        bus.i_md_data  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 31);
        for (int t = 0; t < 8 && m_pend[r]; t++)
          r = $urandom_range(0, 31);
        if (m_pend[r]) r = 0;
        bus.i_alu_valid = 1'b1;
        bus.i_alu_rd    = RegAddr'(r);
        bus.i_alu_data  = $urandom;
      end
      bus.i_issue_valid = ($urandom_range(0, 2) == 0);
      bus.i_issue_rd    = RegAddr'($urandom_range(0, 31));
      bus.i_rs1         = RegAddr'($urandom_range(0, 31));
      bus.i_rs2         = RegAddr'($urandom_range(0, 31));
    end

    @(negedge clk);
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
